operand_fetch_stage: RTL

//  Decode->execute stage that reads source operands. Drives rs1/rs2 addresses to register_file
//  (1-cycle synchronous read, internal write bypass), holds one instruction, and emits it with
//  rs1_val/rs2_val. A per-register pending-write scoreboard stalls issue on RAW hazards.

---
 rtl/operand_fetch_stage_pkg.sv | 42 ++++
 rtl/operand_fetch_stage_reg_scoreboard.sv | 60 ++++++
 rtl/operand_fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : operand_fetch_stage_pkg
// Brief  : Shared types for the operand fetch stage and its scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
package operand_fetch_stage_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int OF_CTRL_W = 16;  // storage width of the slot control field

  typedef logic [4:0] rv_reg_t;

  typedef struct packed {
    logic    writes_rd;
    rv_reg_t rd;
  } reg_write_control_t;

  // One held instruction. CTRL_W of the stage must not exceed OF_CTRL_W.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    rv_reg_t              rs1;
    rv_reg_t              rs2;
    rv_reg_t              rd;
    logic                 writes_rd;
    logic [XLEN-1:0]      imm;
    logic [OF_CTRL_W-1:0] ctrl;
  } of_slot_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // x0 is hardwired zero: never a real source or destination.
  function automatic logic is_x0(input rv_reg_t r);
    return (r == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : reg_scoreboard
// Brief  : Per-register count of in-flight writers with two hazard lookups
//          and a saturation flag for the issuing instruction's rd.
// Rev    : 1.0  initial release
// ============================================================================
module reg_scoreboard
  import operand_fetch_stage_pkg::*;
#(
  parameter int COUNT_W = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  rv_reg_t inc_rd,
  input  logic    dec,
  input  rv_reg_t dec_rd,
  input  rv_reg_t look1_rd,
  input  rv_reg_t look2_rd,
  input  logic    sat_en,
  input  rv_reg_t sat_rd,
  output logic    busy1,
  output logic    busy2,
  output logic    sat
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0] cnt [NUM_REGS];

  // Counter update; x0 is never tracked and a same-register inc/dec cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc && (inc_rd == rv_reg_t'(i)) && !(dec && (dec_rd == rv_reg_t'(i)))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec && (dec_rd == rv_reg_t'(i)) && !(inc && (inc_rd == rv_reg_t'(i)))
                     && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Lookups: a source is busy while any older writer to it is in flight.
  always_comb begin
    busy1 = !is_x0(look1_rd) && (cnt[look1_rd] != '0);
    busy2 = !is_x0(look2_rd) && (cnt[look2_rd] != '0);
    sat   = sat_en && !is_x0(sat_rd) && (cnt[sat_rd] == CNT_MAX);
  end

  // A release must always match an outstanding writer.
  a_release_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !is_x0(dec_rd) && (cnt[dec_rd] == '0) && !(inc && (inc_rd == dec_rd))));

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : operand_fetch_stage
// Brief  : Single-slot decode->execute stage. Reads operands from the
//          register file every cycle and stalls on RAW hazards tracked by a
//          pending-write scoreboard. No forwarding.
// Rev    : 1.0  initial release
// ============================================================================
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int CTRL_W     = OF_CTRL_W,
  parameter int SB_COUNT_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  rv_reg_t           in_rs1,
  input  rv_reg_t           in_rs2,
  input  rv_reg_t           in_rd,
  input  logic              in_writes_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output rv_reg_t           rf_rs1,
  output rv_reg_t           rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_val,
  input  logic [XLEN-1:0]   rf_rs2_val,
  input  logic              release_valid,
  input  rv_reg_t           release_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output rv_reg_t           out_rd,
  output logic              out_writes_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val
);

  slot_state_t state_q, state_d;
  of_slot_t    slot_q;
  logic        accept;
  logic        out_fire;
  logic        hazard;
  logic        busy1, busy2, sat;
  logic        sb_inc, sb_dec;

  // Slot state register; reset discards the held instruction at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SLOT_EMPTY;
    else       state_q <= state_d;
  end

  // Handshake and next-state: flush wins, then accept, then drain.
  always_comb begin
    state_d   = state_q;
    hazard    = busy1 || busy2;
    out_valid = (state_q == SLOT_FULL) && !hazard && !sat && !flush;
    out_fire  = out_valid && out_ready;
    in_ready  = !reset && !flush && ((state_q == SLOT_EMPTY) || out_fire);
    accept    = in_valid && in_ready;
    if (flush)         state_d = SLOT_EMPTY;
    else if (accept)   state_d = SLOT_FULL;
    else if (out_fire) state_d = SLOT_EMPTY;
  end

  // Instruction fields captured on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else if (accept) begin
      slot_q.pc        <= in_pc;
      slot_q.rs1       <= in_rs1;
      slot_q.rs2       <= in_rs2;
      slot_q.rd        <= in_rd;
      slot_q.writes_rd <= in_writes_rd;
      slot_q.imm       <= in_imm;
      slot_q.ctrl      <= OF_CTRL_W'(in_ctrl);
    end
  end

  // Register file addressing: the incoming instruction on accept, otherwise
  // the held one so that writes landing during a stall are picked up.
  always_comb begin
    rf_rs1 = accept ? in_rs1 : slot_q.rs1;
    rf_rs2 = accept ? in_rs2 : slot_q.rs2;
  end

  // Output fields; x0 sources read as zero whatever the register file returns.
  always_comb begin
    out_pc        = slot_q.pc;
    out_imm       = slot_q.imm;
    out_rd        = slot_q.rd;
    out_writes_rd = slot_q.writes_rd;
    out_ctrl      = CTRL_W'(slot_q.ctrl);
    out_rs1_val   = is_x0(slot_q.rs1) ? '0 : rf_rs1_val;
    out_rs2_val   = is_x0(slot_q.rs2) ? '0 : rf_rs2_val;
  end

  // Scoreboard events: issue of a real writer, and release from downstream.
  always_comb begin
    sb_inc = out_fire && slot_q.writes_rd && !is_x0(slot_q.rd);
    sb_dec = release_valid && !is_x0(release_rd);
  end

  reg_scoreboard #(
    .COUNT_W (SB_COUNT_W)
  ) u_scoreboard (
    .clk      (clock),
    .rst      (reset),
    .inc      (sb_inc),
    .inc_rd   (slot_q.rd),
    .dec      (sb_dec),
    .dec_rd   (release_rd),
    .look1_rd (slot_q.rs1),
    .look2_rd (slot_q.rs2),
    .sat_en   (slot_q.writes_rd),
    .sat_rd   (slot_q.rd),
    .busy1    (busy1),
    .busy2    (busy2),
    .sat      (sat)
  );

endmodule
`default_nettype wire
